dbg_hart_ctrl: RTL and testbench

Per-hart debug controller for the rv32imf core, a parametrised successor to the single-trigger-free halt/resume FSM. It provides:
- halt/resume/single-step sequencing with pipeline drain;
- a NUM_TRIG-deep bank of PC-match hardware breakpoints;
- dcsr/dpc/tselect/tdata1/tdata2 CSRs;
- a registered abstract-register access port toward the debug module.

It sits in the core top between the debug module interface and the control unit / datapath.

---
 rtl/dbg_pkg.sv | 40 ++++
 rtl/dbg_trig_bank.sv | 56 +++++
 rtl/dbg_hart_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_dbg_hart_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the per-hart debug controller.
// Contents: FSM state type, halt-cause codes, debug CSR addresses,
// abstract register-number windows, dcsr reset value and a dcsr
// packing helper.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING,
    ST_DRAIN,
    ST_HALTED,
    ST_RESUME
  } dbg_state_t;

  localparam logic [2:0] CAUSE_NONE      = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
  localparam logic [2:0] CAUSE_TRIG      = 3'd2;
  localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
  localparam logic [2:0] CAUSE_STEP      = 3'd4;
  localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

  localparam logic [15:0] CSR_DCSR    = 16'h07B0;
  localparam logic [15:0] CSR_DPC     = 16'h07B1;
  localparam logic [15:0] CSR_TSELECT = 16'h07A0;
  localparam logic [15:0] CSR_TDATA1  = 16'h07A1;
  localparam logic [15:0] CSR_TDATA2  = 16'h07A2;

  // Register-number windows (upper 11 bits) for GPR / FPR reads
  localparam logic [10:0] AR_GPR_WIN = 11'h080;  // 0x1000-0x101F
  localparam logic [10:0] AR_FPR_WIN = 11'h081;  // 0x1020-0x103F

  localparam logic [31:0] DCSR_RST    = 32'h4000_0003;
  localparam logic [3:0]  TDATA1_TYPE = 4'd2;

  function automatic logic [31:0] dcsr_pack(input logic       ebreakm,
                                            input logic [2:0] cause,
                                            input logic       step);
    return DCSR_RST | {16'b0, ebreakm, 6'b0, cause, 3'b0, step, 2'b0};
  endfunction

endpackage

// File: rtl/dbg_trig_bank.sv
// Bank of NUM_TRIG PC-match breakpoints.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   i_we_tdata1/2      write strobes for the selected trigger
//   i_tsel             selected trigger index
//   i_wdata            write data (tdata1 keeps only bit 2)
//   i_mem_valid/pc     MEM-stage instruction
//   o_tdata1_en        enable bit of the selected trigger
//   o_tdata2           match address of the selected trigger
//   o_match            any enabled trigger matches the MEM PC
module dbg_trig_bank #(
  parameter int XLEN     = 32,
  parameter int NUM_TRIG = 2,
  parameter int TSEL_W   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we_tdata1,
  input  logic              i_we_tdata2,
  input  logic [TSEL_W-1:0] i_tsel,
  input  logic [31:0]       i_wdata,
  input  logic              i_mem_valid,
  input  logic [XLEN-1:0]   i_mem_pc,
  output logic              o_tdata1_en,
  output logic [XLEN-1:0]   o_tdata2,
  output logic              o_match
);

  logic            r_en [NUM_TRIG];
  logic [XLEN-1:0] r_t2 [NUM_TRIG];
  logic            w_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_TRIG; i++) begin
        r_en[i] <= 1'b0;
        r_t2[i] <= '0;
      end
    end else begin
      if (i_we_tdata1) r_en[i_tsel] <= i_wdata[2];
      if (i_we_tdata2) r_t2[i_tsel] <= XLEN'(i_wdata);
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_TRIG; i++) begin
      if (r_en[i] && (r_t2[i] == i_mem_pc)) w_hit = 1'b1;
    end
  end

  assign o_match     = i_mem_valid & w_hit;
  assign o_tdata1_en = r_en[i_tsel];
  assign o_tdata2    = r_t2[i_tsel];

endmodule

// File: rtl/dbg_hart_ctrl.sv
// Per-hart debug controller: halt/resume/single-step sequencing with
// pipeline drain, PC-match triggers, debug CSRs and a registered
// abstract-register access port.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   dbg_haltreq/resumereq        level requests from the debug module
//   core_resumeack, dbg_ret      one-cycle pulses in RESUME
//   core_running/halted          FSM state flags
//   debug_on                     stop fetch / drain
//   dpc_o, dcsr_o                current dpc / dcsr
//   empty_core                   pipeline empty
//   mem_valid/pc, ebreak_inst_mem  MEM-stage instruction
//   trig_flush                   kill MEM instruction
//   inst_valid_wb, cinst_pc, branch_wb, pc_jump_wb  retirement info
//   dbg_ar_*                     abstract access port
//   dbg_gpr_rdata(_f)            GPR / FPR read data
module dbg_hart_ctrl
  import dbg_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NUM_TRIG      = 2,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dbg_haltreq,
  input  logic            dbg_resumereq,
  output logic            core_resumeack,
  output logic            core_running,
  output logic            core_halted,
  output logic            debug_on,
  output logic            dbg_ret,
  output logic [XLEN-1:0] dpc_o,
  output logic [31:0]     dcsr_o,
  input  logic            empty_core,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            ebreak_inst_mem,
  output logic            trig_flush,
  input  logic            inst_valid_wb,
  input  logic [XLEN-1:0] cinst_pc,
  input  logic            branch_wb,
  input  logic [XLEN-1:0] pc_jump_wb,
  input  logic            dbg_ar_en,
  input  logic            dbg_ar_wr,
  input  logic [15:0]     dbg_ar_ad,
  input  logic [31:0]     dbg_ar_do,
  input  logic [31:0]     dbg_gpr_rdata,
  input  logic [31:0]     dbg_gpr_rdata_f,
  output logic [31:0]     dbg_ar_di,
  output logic            dbg_ar_done
);

  localparam int TSEL_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;

  dbg_state_t      r_state;
  logic [2:0]      r_cause;
  logic            r_ebreakm;
  logic            r_step;
  logic [XLEN-1:0] r_dpc;
  logic [XLEN-1:0] r_next_pc;
  logic [TSEL_W-1:0] r_tsel;
  logic            r_step_pending;
  logic            r_resume_armed;
  logic            r_ar_done;
  logic [31:0]     r_ar_di;

  logic            w_trig_hit;
  logic            w_ebrk;
  logic            w_step;
  logic [2:0]      w_cause;
  logic            w_halt;
  logic            w_wr_ok;
  logic            w_we_t1;
  logic            w_we_t2;
  logic            w_t1_en;
  logic [XLEN-1:0] w_t2;
  logic [31:0]     w_rdata;

  assign w_wr_ok = dbg_ar_en & dbg_ar_wr & (r_state == ST_HALTED);
  assign w_we_t1 = w_wr_ok & (dbg_ar_ad == CSR_TDATA1);
  assign w_we_t2 = w_wr_ok & (dbg_ar_ad == CSR_TDATA2);

  dbg_trig_bank #(
    .XLEN    (XLEN),
    .NUM_TRIG(NUM_TRIG),
    .TSEL_W  (TSEL_W)
  ) u_trig (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we_tdata1(w_we_t1),
    .i_we_tdata2(w_we_t2),
    .i_tsel     (r_tsel),
    .i_wdata    (dbg_ar_do),
    .i_mem_valid(mem_valid),
    .i_mem_pc   (mem_pc),
    .o_tdata1_en(w_t1_en),
    .o_tdata2   (w_t2),
    .o_match    (w_trig_hit)
  );

  // Halt source arbitration: trigger > ebreak > haltreq > step
  always_comb begin
    w_ebrk  = mem_valid & ebreak_inst_mem & r_ebreakm;
    w_step  = r_step_pending & inst_valid_wb;
    w_cause = CAUSE_NONE;
    if (w_trig_hit)       w_cause = CAUSE_TRIG;
    else if (w_ebrk)      w_cause = CAUSE_EBREAK;
    else if (dbg_haltreq) w_cause = CAUSE_HALTREQ;
    else if (w_step)      w_cause = CAUSE_STEP;
    w_halt = (r_state == ST_RUNNING) && (w_cause != CAUSE_NONE);
  end

  assign trig_flush = w_halt & (w_trig_hit | w_ebrk);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= HALT_ON_RESET ? ST_DRAIN : ST_RUNNING;
      r_cause        <= HALT_ON_RESET ? CAUSE_RESETHALT : CAUSE_NONE;
      r_ebreakm      <= 1'b0;
      r_step         <= 1'b0;
      r_dpc          <= '0;
      r_next_pc      <= '0;
      r_tsel         <= '0;
      r_step_pending <= 1'b0;
      r_resume_armed <= 1'b1;
    end else begin
      if (inst_valid_wb)
        r_next_pc <= branch_wb ? pc_jump_wb : cinst_pc + XLEN'(4);
      if (!dbg_resumereq) r_resume_armed <= 1'b1;

      case (r_state)
        ST_RUNNING: begin
          if (w_halt) begin
            r_state        <= ST_DRAIN;
            r_cause        <= w_cause;
            r_step_pending <= 1'b0;
            r_dpc          <= (w_trig_hit | w_ebrk) ? mem_pc : r_next_pc;
          end
        end
        ST_DRAIN: begin
          if (empty_core) begin
            r_state <= ST_HALTED;
            // Asynchronous causes take the PC after the last retirement
            if (r_cause != CAUSE_TRIG && r_cause != CAUSE_EBREAK)
              r_dpc <= r_next_pc;
          end
        end
        ST_HALTED: begin
          if (dbg_resumereq && r_resume_armed) begin
            r_state        <= ST_RESUME;
            r_resume_armed <= 1'b0;
          end
        end
        ST_RESUME: begin
          r_state        <= ST_RUNNING;
          r_next_pc      <= r_dpc;
          r_step_pending <= r_step;
        end
        default: r_state <= ST_RUNNING;
      endcase

      if (w_wr_ok) begin
        case (dbg_ar_ad)
          CSR_DCSR: begin
            r_ebreakm <= dbg_ar_do[15];
            r_step    <= dbg_ar_do[2];
          end
          CSR_DPC: r_dpc <= XLEN'(dbg_ar_do) & ~XLEN'(3);
          CSR_TSELECT: begin
            if (dbg_ar_do >= 32'(NUM_TRIG)) r_tsel <= TSEL_W'(NUM_TRIG - 1);
            else                            r_tsel <= dbg_ar_do[TSEL_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (dbg_ar_ad)
      CSR_DCSR:    w_rdata = dcsr_o;
      CSR_DPC:     w_rdata = 32'(r_dpc);
      CSR_TSELECT: w_rdata = 32'(r_tsel);
      CSR_TDATA1:  w_rdata = {TDATA1_TYPE, 25'b0, w_t1_en, 2'b0};
      CSR_TDATA2:  w_rdata = 32'(w_t2);
      default: begin
        if (dbg_ar_ad[15:5] == AR_GPR_WIN)      w_rdata = dbg_gpr_rdata;
        else if (dbg_ar_ad[15:5] == AR_FPR_WIN) w_rdata = dbg_gpr_rdata_f;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ar_done <= 1'b0;
      r_ar_di   <= '0;
    end else begin
      r_ar_done <= dbg_ar_en;
      if (dbg_ar_en) r_ar_di <= w_rdata;
    end
  end

  assign dcsr_o         = dcsr_pack(r_ebreakm, r_cause, r_step);
  assign dpc_o          = r_dpc;
  assign core_running   = (r_state == ST_RUNNING);
  assign core_halted    = (r_state == ST_HALTED);
  assign debug_on       = (r_state == ST_DRAIN) || (r_state == ST_HALTED);
  assign dbg_ret        = (r_state == ST_RESUME);
  assign core_resumeack = (r_state == ST_RESUME);
  assign dbg_ar_done    = r_ar_done;
  assign dbg_ar_di      = r_ar_di;

endmodule

// File: tb/tb_dbg_hart_ctrl.sv
module tb_dbg_hart_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, r2_n;
  logic        dbg_haltreq, dbg_resumereq;
  logic        empty_core, mem_valid, ebreak_inst_mem;
  logic [31:0] mem_pc, cinst_pc, pc_jump_wb;
  logic        inst_valid_wb, branch_wb;
  logic        dbg_ar_en, dbg_ar_wr;
  logic [15:0] dbg_ar_ad;
  logic [31:0] dbg_ar_do, dbg_gpr_rdata, dbg_gpr_rdata_f;

  logic        core_resumeack, core_running, core_halted, debug_on, dbg_ret;
  logic [31:0] dpc_o, dcsr_o, dbg_ar_di;
  logic        trig_flush, dbg_ar_done;

  logic        hr_ack, hr_running, hr_halted, hr_debug_on, hr_ret, hr_flush, hr_done;
  logic [31:0] hr_dpc, hr_dcsr, hr_di;

  dbg_hart_ctrl #(.XLEN(32), .NUM_TRIG(2), .HALT_ON_RESET(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .dbg_haltreq(dbg_haltreq), .dbg_resumereq(dbg_resumereq),
    .core_resumeack(core_resumeack), .core_running(core_running), .core_halted(core_halted),
    .debug_on(debug_on), .dbg_ret(dbg_ret), .dpc_o(dpc_o), .dcsr_o(dcsr_o),
    .empty_core(empty_core), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .ebreak_inst_mem(ebreak_inst_mem), .trig_flush(trig_flush), .inst_valid_wb(inst_valid_wb),
    .cinst_pc(cinst_pc), .branch_wb(branch_wb), .pc_jump_wb(pc_jump_wb),
    .dbg_ar_en(dbg_ar_en), .dbg_ar_wr(dbg_ar_wr), .dbg_ar_ad(dbg_ar_ad), .dbg_ar_do(dbg_ar_do),
    .dbg_gpr_rdata(dbg_gpr_rdata), .dbg_gpr_rdata_f(dbg_gpr_rdata_f),
    .dbg_ar_di(dbg_ar_di), .dbg_ar_done(dbg_ar_done)
  );

  dbg_hart_ctrl #(.XLEN(32), .NUM_TRIG(2), .HALT_ON_RESET(1'b1)) u_hr (
    .clk(clk), .reset_n(r2_n), .dbg_haltreq(1'b0), .dbg_resumereq(1'b0),
    .core_resumeack(hr_ack), .core_running(hr_running), .core_halted(hr_halted),
    .debug_on(hr_debug_on), .dbg_ret(hr_ret), .dpc_o(hr_dpc), .dcsr_o(hr_dcsr),
    .empty_core(empty_core), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .ebreak_inst_mem(ebreak_inst_mem), .trig_flush(hr_flush), .inst_valid_wb(inst_valid_wb),
    .cinst_pc(cinst_pc), .branch_wb(branch_wb), .pc_jump_wb(pc_jump_wb),
    .dbg_ar_en(1'b0), .dbg_ar_wr(1'b0), .dbg_ar_ad(16'h0), .dbg_ar_do(32'h0),
    .dbg_gpr_rdata(32'h0), .dbg_gpr_rdata_f(32'h0),
    .dbg_ar_di(hr_di), .dbg_ar_done(hr_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct { logic chk; logic [31:0] d; string nm; } ar_exp_t;
  typedef struct { logic [31:0] dpc; logic [2:0] cause; } halt_exp_t;
  ar_exp_t   arq[$];
  halt_exp_t hq[$];

  // ---------------- reference model ----------------
  logic        m_halted, m_ebreakm, m_step;
  logic [2:0]  m_cause;
  logic [31:0] m_dpc;
  int          m_tsel;
  logic        m_t1 [2];
  logic [31:0] m_t2 [2];
  int          m_resumes = 0;
  int          ack_cnt   = 0;

  task automatic m_reset();
    m_halted = 0; m_ebreakm = 0; m_step = 0; m_cause = 0; m_dpc = 0; m_tsel = 0;
    for (int i = 0; i < 2; i++) begin m_t1[i] = 0; m_t2[i] = 0; end
  endtask

  function automatic logic [31:0] m_dcsr();
    return 32'h4000_0000 + (m_ebreakm ? 32'h8000 : 32'h0) + (32'(m_cause) * 64)
           + (m_step ? 32'h4 : 32'h0) + 32'h3;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a, input logic [31:0] g,
                                         input logic [31:0] gf);
    if (a == 16'h07B0) return m_dcsr();
    if (a == 16'h07B1) return m_dpc;
    if (a == 16'h07A0) return 32'(m_tsel);
    if (a == 16'h07A1) return 32'h2000_0000 + (m_t1[m_tsel] ? 32'h4 : 32'h0);
    if (a == 16'h07A2) return m_t2[m_tsel];
    if (a >= 16'h1000 && a <= 16'h101F) return g;
    if (a >= 16'h1020 && a <= 16'h103F) return gf;
    return 32'h0;
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [31:0] d);
    if (!m_halted) return;
    case (a)
      16'h07B0: begin m_ebreakm = d[15]; m_step = d[2]; end
      16'h07B1: m_dpc = {d[31:2], 2'b00};
      16'h07A0: m_tsel = (d >= 32'd2) ? 1 : int'(d);
      16'h07A1: m_t1[m_tsel] = d[2];
      16'h07A2: m_t2[m_tsel] = d;
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ar(input logic wr, input logic [15:0] a, input logic [31:0] d,
                    input logic [31:0] g, input string nm);
    ar_exp_t e;
    logic [31:0] gf;
    gf = $urandom;
    dbg_ar_en = 1; dbg_ar_wr = wr; dbg_ar_ad = a; dbg_ar_do = d;
    dbg_gpr_rdata = g; dbg_gpr_rdata_f = gf;
    e.chk = !wr; e.d = m_read(a, g, gf); e.nm = nm;
    arq.push_back(e);
    if (wr) m_write(a, d);
    tick();
    dbg_ar_en = 0; dbg_ar_wr = 0;
  endtask

  task automatic push_halt(input logic [31:0] dpc, input logic [2:0] cause);
    halt_exp_t h;
    h.dpc = dpc; h.cause = cause;
    hq.push_back(h);
    m_dpc = dpc; m_cause = cause;
  endtask

  task automatic wait_halted(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (core_halted) break;
      tick();
    end
    chk({nm, "_halt_reached"}, 32'(core_halted), 32'd1);
    m_halted = 1;
  endtask

  task automatic resume(input logic hold);
    dbg_resumereq = 1;
    m_halted = 0;
    tick();
    dbg_resumereq = hold;
    @(negedge clk);
    chk("resume_ack", 32'(core_resumeack), 32'd1);
    chk("resume_ret", 32'(dbg_ret), 32'd1);
    m_resumes++;
    tick();
    chk("running_after_resume", 32'(core_running), 32'd1);
  endtask

  task automatic clear_pipe();
    mem_valid = 0; ebreak_inst_mem = 0; inst_valid_wb = 0; branch_wb = 0; dbg_haltreq = 0;
  endtask

  // ---------------- monitor ----------------
  logic prev_h = 1'b0;
  always @(negedge clk) begin
    if (dbg_ar_done) begin
      if (arq.size() == 0) begin
        checks++; errors++;
        $display("FAIL ar_done_unexpected actual=1 required=0");
      end else begin
        ar_exp_t e;
        e = arq.pop_front();
        if (e.chk) chk(e.nm, dbg_ar_di, e.d);
      end
    end
    if (core_halted && !prev_h) begin
      if (hq.size() == 0) begin
        checks++; errors++;
        $display("FAIL halt_unexpected dpc=%h", dpc_o);
      end else begin
        halt_exp_t h;
        h = hq.pop_front();
        chk("halt_dpc", dpc_o, h.dpc);
        chk("halt_cause", 32'(dcsr_o[8:6]), 32'(h.cause));
      end
    end
    prev_h = core_halted;
    if (core_resumeack) ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] src, tgt, t, t1, r;
    logic [15:0] addrs [6];
    int n;

    reset_n = 0; r2_n = 0;
    dbg_haltreq = 0; dbg_resumereq = 0; empty_core = 1;
    mem_valid = 0; mem_pc = 0; ebreak_inst_mem = 0;
    inst_valid_wb = 0; cinst_pc = 0; branch_wb = 0; pc_jump_wb = 0;
    dbg_ar_en = 0; dbg_ar_wr = 0; dbg_ar_ad = 0; dbg_ar_do = 0;
    dbg_gpr_rdata = 0; dbg_gpr_rdata_f = 0;
    m_reset();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_running", 32'(core_running), 32'd1);
    chk("rst_debug_on", 32'(debug_on), 32'd0);
    chk("rst_dcsr", dcsr_o, 32'h4000_0003);
    chk("rst_dpc", dpc_o, 32'h0);
    chk("rst_ar_di", dbg_ar_di, 32'h0);
    chk("rst_ret", 32'(dbg_ret), 32'd0);
    chk("hr_rst_debug_on", 32'(hr_debug_on), 32'd1);
    chk("hr_rst_dcsr", hr_dcsr, 32'h4000_0143);
    tick();
    reset_n = 1;
    tick();

    // 1: haltreq while a jump retires
    src = $urandom & 32'hFFFF_FFFC;
    tgt = $urandom & 32'hFFFF_FFFC;
    empty_core = 0;
    dbg_haltreq = 1; inst_valid_wb = 1; cinst_pc = src; branch_wb = 1; pc_jump_wb = tgt;
    push_halt(tgt, 3'd3);
    tick();
    clear_pipe();
    chk("drain_debug_on", 32'(debug_on), 32'd1);
    chk("drain_not_halted", 32'(core_halted), 32'd0);
    tick();
    empty_core = 1;
    wait_halted("t1");
    ar(0, 16'h07B0, 0, $urandom, "rd_dcsr_t1");

    // 2: trigger programming and hit
    t  = 32'h0000_0340;
    t1 = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
    ar(1, 16'h07A0, 32'd5, 0, "wr_tsel_clamp");
    ar(0, 16'h07A0, 0, 0, "rd_tsel_clamp");
    ar(1, 16'h07A1, 32'hFFFF_FFFF, 0, "wr_tdata1_1");
    ar(0, 16'h07A1, 0, 0, "rd_tdata1_1");
    ar(1, 16'h07A2, t1, 0, "wr_tdata2_1");
    ar(0, 16'h07A2, 0, 0, "rd_tdata2_1");
    ar(1, 16'h07A0, 32'd0, 0, "wr_tsel0");
    ar(1, 16'h07A2, t, 0, "wr_tdata2_0");
    ar(1, 16'h07A1, 32'h4, 0, "wr_tdata1_0");
    ar(0, 16'h07A1, 0, 0, "rd_tdata1_0");
    ar(0, 16'h07A2, 0, 0, "rd_tdata2_0");
    addrs = '{16'h1000, 16'h1020, 16'h07B1, 16'h0123, 16'h1040, 16'h0FFF};
    for (int i = 0; i < 6; i++) begin
      logic [15:0] a;
      a = addrs[i];
      if (a == 16'h1000 || a == 16'h1020) a = a + 16'($urandom_range(0, 31));
      ar(0, a, 0, $urandom, "rd_rand_halted");
    end
    resume(1'b1);
    empty_core = 0;
    for (int k = 1; k <= 3; k++) begin
      mem_valid = 1; mem_pc = t + 32'(4 * k);
      @(negedge clk);
      chk("flush_nomatch", 32'(trig_flush), 32'd0);
      tick();
    end
    mem_valid = 1; mem_pc = t;
    @(negedge clk);
    chk("flush_trig", 32'(trig_flush), 32'd1);
    push_halt(t, 3'd2);
    tick();
    clear_pipe();
    empty_core = 1;
    wait_halted("t2");
    repeat (3) tick();
    chk("resumereq_no_rearm", 32'(core_halted), 32'd1);
    dbg_resumereq = 0;
    tick();

    // 3: single step
    ar(1, 16'h07A1, 32'h0, 0, "dis_trig0");
    ar(1, 16'h07A0, 32'd1, 0, "wr_tsel1");
    ar(1, 16'h07A1, 32'h0, 0, "dis_trig1");
    ar(1, 16'h07B0, 32'h0000_8004, 0, "wr_dcsr_step");
    ar(1, 16'h07B1, 32'h0000_0013, 0, "wr_dpc_10");
    ar(0, 16'h07B1, 0, 0, "rd_dpc_10");
    resume(1'b0);
    empty_core = 0;
    tick(); tick();
    chk("step_waits", 32'(core_running), 32'd1);
    inst_valid_wb = 1; cinst_pc = 32'h10; branch_wb = 0;
    push_halt(32'h14, 3'd4);
    tick();
    clear_pipe();
    chk("step_drain", 32'(debug_on), 32'd1);
    empty_core = 1;
    wait_halted("t3");

    // 4a: ebreak with ebreakm beats haltreq
    ar(1, 16'h07B0, 32'h0000_8000, 0, "wr_dcsr_ebm");
    resume(1'b0);
    empty_core = 0;
    mem_valid = 1; mem_pc = 32'h80; ebreak_inst_mem = 1; dbg_haltreq = 1;
    @(negedge clk);
    chk("flush_ebreak", 32'(trig_flush), 32'd1);
    push_halt(32'h80, 3'd1);
    tick();
    clear_pipe();
    empty_core = 1;
    wait_halted("t4a");

    // 4b: ebreak ignored without ebreakm
    ar(1, 16'h07B0, 32'h0, 0, "wr_dcsr_0");
    resume(1'b0);
    empty_core = 0;
    r = $urandom & 32'h7FFF_FFFC;
    mem_valid = 1; mem_pc = 32'h80; ebreak_inst_mem = 1; dbg_haltreq = 1;
    inst_valid_wb = 1; cinst_pc = r; branch_wb = 0;
    @(negedge clk);
    chk("flush_ebreak_off", 32'(trig_flush), 32'd0);
    push_halt(r + 32'd4, 3'd3);
    tick();
    clear_pipe();
    empty_core = 1;
    wait_halted("t4b");

    // 5: abstract access while running
    resume(1'b0);
    ar(0, 16'h1005, 0, 32'hDEAD_BEEF, "rd_gpr5");
    ar(1, 16'h07B1, $urandom, 0, "wr_dpc_run");
    ar(0, 16'h07B1, 0, 0, "rd_dpc_keep");
    ar(1, 16'h07B0, 32'h0000_8004, 0, "wr_dcsr_run");
    ar(0, 16'h07B0, 0, 0, "rd_dcsr_keep");
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(16'h0FF0, 16'h1050));
      ar(0, a, 0, $urandom, "rd_rand_run");
    end
    tick();

    // reset while in DRAIN, with an access in flight
    empty_core = 0;
    dbg_haltreq = 1;
    tick();
    dbg_haltreq = 0;
    chk("drain_before_rst", 32'(debug_on), 32'd1);
    reset_n = 0;
    dbg_ar_en = 1; dbg_ar_wr = 0; dbg_ar_ad = 16'h1005;
    tick();
    reset_n = 1; dbg_ar_en = 0;
    m_reset();
    @(negedge clk);
    chk("rst_drain_running", 32'(core_running), 32'd1);
    chk("rst_drain_dcsr", dcsr_o, 32'h4000_0003);
    chk("rst_drain_dpc", dpc_o, 32'h0);
    tick();
    empty_core = 1;

    // 6: halt-on-reset instance
    r2_n = 1;
    n = 0;
    while (!hr_halted && n < 6) begin
      tick();
      n++;
    end
    chk("hr_halt_cycles_ok", 32'(n >= 1 && n <= 2), 32'd1);
    chk("hr_cause", 32'(hr_dcsr[8:6]), 32'd5);
    chk("hr_dpc", hr_dpc, 32'h0);

    repeat (3) tick();
    chk("arq_drained", 32'(arq.size()), 32'd0);
    chk("hq_drained", 32'(hq.size()), 32'd0);
    chk("resumeack_count", 32'(ack_cnt), 32'(m_resumes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
